// File: rtl/loop_fetch_stage.sv
// Instruction fetch stage fed by the loop-buffer controller: owns the PC, drives imem, fills IF/ID.
// Latency: imem_addr is the combinational next PC; IF/ID is registered one cycle after curr_PC.
// Backpressure: stall holds PC, IF/ID and the replay counter; flush and branch redirects override stall.
module loop_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               block_signal,
  input  logic               flush,
  input  logic [31:0]        new_pc,
  input  logic [31:0]        lb_instruction,
  input  logic [31:0]        imem_instruction,
  output logic [31:0]        imem_addr,
  output logic [31:0]        curr_PC,
  output logic [31:0]        if_id_instruction,
  output logic [31:0]        if_id_pc,
  output logic               if_id_valid,
  output logic [COUNT_W-1:0] replay_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    LOOP    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        npc;
  logic [31:0]        instr_nxt;
  logic [31:0]        pc_nxt;
  logic               valid_nxt;
  logic [COUNT_W-1:0] count_nxt;
  logic               count_sat;

  // Counter is pinned once every bit is set.
  assign count_sat = &replay_count;

  // Next PC: redirects win over stall; the PC is frozen while replaying from the loop buffer.
  always_comb begin
    npc = curr_PC + 32'd4;
    if (flush) begin
      npc = new_pc;
    end else if (branch_taken) begin
      npc = branch_target;
    end else if (stall || (state == LOOP)) begin
      npc = curr_PC;
    end
  end

  // While reset is held the memory must see the reset vector, not a stale next PC.
  assign imem_addr = reset ? npc : RESET_PC;

  // Next-state and IF/ID/counter updates; every path starts by holding the current contents.
  always_comb begin
    state_nxt = state;
    instr_nxt = if_id_instruction;
    pc_nxt    = if_id_pc;
    valid_nxt = if_id_valid;
    count_nxt = replay_count;

    unique case (state)
      FETCH: begin
        if (flush) begin
          // The loop controller only flushes out of replay; treat a stray one as a full redirect.
          valid_nxt = 1'b0;
          state_nxt = RECOVER;
        end else if (branch_taken) begin
          // Target word arrives next cycle, so a single bubble is enough.
          valid_nxt = 1'b0;
        end else if (!stall) begin
          instr_nxt = imem_instruction;
          pc_nxt    = curr_PC;
          valid_nxt = 1'b1;
          if (block_signal) begin
            state_nxt = LOOP;
          end
        end
      end

      LOOP: begin
        if (flush) begin
          valid_nxt = 1'b0;
          state_nxt = RECOVER;
        end else if (branch_taken) begin
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (!stall) begin
          if (block_signal) begin
            instr_nxt = lb_instruction;
            pc_nxt    = curr_PC;
            valid_nxt = 1'b1;
            count_nxt = count_sat ? replay_count : replay_count + COUNT_W'(1);
          end else begin
            // Controller wait cycle: nothing to deliver this cycle.
            valid_nxt = 1'b0;
          end
        end
      end

      RECOVER: begin
        // Second bubble while memory reads the restored PC; a fresh redirect restarts recovery.
        valid_nxt = 1'b0;
        if (!(flush || branch_taken)) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        valid_nxt = 1'b0;
        state_nxt = FETCH;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // PC register tracks the next PC every cycle, so imem data always corresponds to curr_PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curr_PC <= RESET_PC;
    end else begin
      curr_PC <= npc;
    end
  end

  // IF/ID pipeline register and the replay performance counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instruction <= NOP;
      if_id_pc          <= 32'h0000_0000;
      if_id_valid       <= 1'b0;
      replay_count      <= '0;
    end else begin
      if_id_instruction <= instr_nxt;
      if_id_pc          <= pc_nxt;
      if_id_valid       <= valid_nxt;
      replay_count      <= count_nxt;
    end
  end

endmodule

// File: tb/tb_loop_fetch_stage.sv
// Directed bench for loop_fetch_stage with a one-cycle synchronous instruction memory model.
// Latency: checks are taken 2 time units after each rising edge.
// Backpressure: stall, flush and branch redirects are driven directly from the step sequence.
module tb_loop_fetch_stage;

  localparam int CW = 3;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic          block_signal;
  logic          flush;
  logic [31:0]   new_pc;
  logic [31:0]   lb_instruction;
  logic [31:0]   imem_instruction;
  logic [31:0]   imem_addr;
  logic [31:0]   curr_PC;
  logic [31:0]   if_id_instruction;
  logic [31:0]   if_id_pc;
  logic          if_id_valid;
  logic [CW-1:0] replay_count;

  int errors;
  int checks;

  loop_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .COUNT_W  (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .block_signal      (block_signal),
    .flush             (flush),
    .new_pc            (new_pc),
    .lb_instruction    (lb_instruction),
    .imem_instruction  (imem_instruction),
    .imem_addr         (imem_addr),
    .curr_PC           (curr_PC),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid),
    .replay_count      (replay_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word is its own address tagged in the top byte.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h0A00_0000 | a;
  endfunction

  // One-cycle synchronous read memory.
  always @(posedge clk) imem_instruction <= word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc, input logic v);
    chk({tag, "_instr"}, if_id_instruction, ins);
    chk({tag, "_pc"}, if_id_pc, pc);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk(tag, {{(32-CW){1'b0}}, replay_count}, 32'(exp));
  endtask

  logic [31:0] lb_seq [3];

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b0;
    stall          = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = 32'h0;
    block_signal   = 1'b0;
    flush          = 1'b0;
    new_pc         = 32'h0;
    lb_instruction = 32'h0;
    lb_seq[0] = 32'hAAAA_0001;
    lb_seq[1] = 32'hBBBB_0002;
    lb_seq[2] = 32'hCCCC_0003;

    // Reset values, and imem_addr pinned to the reset vector while reset is low.
    tick();
    tick();
    chk("rst_pc", curr_PC, 32'h0);
    chk_ifid("rst", 32'h0000_0013, 32'h0, 1'b0);
    chk_cnt("rst_cnt", 0);
    chk("rst_imem_addr", imem_addr, 32'h0);

    // Release: next PC becomes 4 straight away.
    reset = 1'b1;
    #1;
    chk("rel_imem_addr", imem_addr, 32'h4);

    // Sequential fetch up to PC 0x20.
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("seq_pc", curr_PC, 32'(4 * i));
      chk_ifid("seq", word(32'(4 * (i - 1))), 32'(4 * (i - 1)), 1'b1);
    end

    // Stall for three cycles at 0x20.
    stall = 1'b1;
    #1;
    chk("stall_imem_addr", imem_addr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", curr_PC, 32'h20);
      chk_ifid("stall", word(32'h1C), 32'h1C, 1'b1);
    end
    stall = 1'b0;
    #1;
    chk("unstall_imem_addr", imem_addr, 32'h24);
    tick();
    chk("unstall_pc", curr_PC, 32'h24);
    chk_ifid("unstall", word(32'h20), 32'h20, 1'b1);

    // Walk to 0x40, then take a branch to 0x100.
    for (int i = 0; i < 7; i++) tick();
    chk("pre_br_pc", curr_PC, 32'h40);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    #1;
    chk("br_imem_addr", imem_addr, 32'h100);
    tick();
    branch_taken = 1'b0;
    chk("br_pc", curr_PC, 32'h100);
    chk("br_bubble", {31'b0, if_id_valid}, 32'h0);
    tick();
    chk("br_tgt_pc", curr_PC, 32'h104);
    chk_ifid("br_tgt", word(32'h100), 32'h100, 1'b1);

    // Enter replay: the entry cycle still fetches from memory, then the PC freezes.
    block_signal = 1'b1;
    tick();
    chk("lp_entry_pc", curr_PC, 32'h108);
    chk_ifid("lp_entry", word(32'h104), 32'h104, 1'b1);
    chk_cnt("lp_entry_cnt", 0);
    #1;
    chk("lp_imem_addr", imem_addr, 32'h108);
    for (int i = 0; i < 3; i++) begin
      lb_instruction = lb_seq[i];
      tick();
      chk("lp_pc", curr_PC, 32'h108);
      chk_ifid("lp", lb_seq[i], 32'h108, 1'b1);
      chk_cnt("lp_cnt", i + 1);
    end

    // Controller wait cycle.
    block_signal = 1'b0;
    tick();
    chk("wait_valid", {31'b0, if_id_valid}, 32'h0);
    chk("wait_pc", curr_PC, 32'h108);
    chk_cnt("wait_cnt", 3);

    // Flush out of replay to 0x104: two bubbles, PC advances through recovery.
    flush        = 1'b1;
    new_pc       = 32'h104;
    block_signal = 1'b1;
    #1;
    chk("fl_imem_addr", imem_addr, 32'h104);
    tick();
    flush        = 1'b0;
    block_signal = 1'b0;
    chk("fl_pc", curr_PC, 32'h104);
    chk("fl_bubble1", {31'b0, if_id_valid}, 32'h0);
    chk_cnt("fl_cnt", 3);
    tick();
    chk("rec_pc", curr_PC, 32'h108);
    chk("fl_bubble2", {31'b0, if_id_valid}, 32'h0);
    tick();
    chk("post_fl_pc", curr_PC, 32'h10C);
    chk_ifid("post_fl", word(32'h108), 32'h108, 1'b1);
    chk_cnt("post_fl_cnt", 3);

    // Re-enter replay, then flush while stalled.
    block_signal = 1'b1;
    tick();
    chk("lp2_pc", curr_PC, 32'h110);
    stall  = 1'b1;
    flush  = 1'b1;
    new_pc = 32'h80;
    tick();
    stall        = 1'b0;
    flush        = 1'b0;
    block_signal = 1'b0;
    chk("flst_pc", curr_PC, 32'h80);
    chk("flst_valid", {31'b0, if_id_valid}, 32'h0);
    tick();
    chk("flst_rec_pc", curr_PC, 32'h84);
    block_signal = 1'b1;
    tick();
    chk("lp3_entry_pc", curr_PC, 32'h88);
    chk_ifid("lp3_entry", word(32'h84), 32'h84, 1'b1);

    // One replay, then a stalled cycle must hold the counter and IF/ID.
    lb_instruction = 32'hDDDD_0004;
    tick();
    chk_cnt("lp3_cnt4", 4);
    stall          = 1'b1;
    lb_instruction = 32'hEEEE_0005;
    tick();
    chk_cnt("stall_cnt", 4);
    chk_ifid("lp_stall", 32'hDDDD_0004, 32'h88, 1'b1);
    stall = 1'b0;

    // Count up to all ones and stay there.
    for (int i = 5; i <= 9; i++) begin
      tick();
      chk_cnt("sat_cnt", (i > 7) ? 7 : i);
    end

    // Branch out of replay back to sequential fetch.
    block_signal  = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    chk("lpbr_pc", curr_PC, 32'h200);
    chk("lpbr_valid", {31'b0, if_id_valid}, 32'h0);
    tick();
    chk("lpbr_next_pc", curr_PC, 32'h204);
    chk_ifid("lpbr", word(32'h200), 32'h200, 1'b1);
    chk_cnt("lpbr_cnt", 7);

    // Reset mid-operation takes effect without a clock edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_pc", curr_PC, 32'h0);
    chk_ifid("mid_rst", 32'h0000_0013, 32'h0, 1'b0);
    chk_cnt("mid_rst_cnt", 0);
    chk("mid_rst_imem_addr", imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
